first_stage_sequencer: RTL
==========================

FIRST_STAGE_SEQUENCER -- requirements
Module: first_stage_sequencer

Interface
REQ-001 Parameter VEC_LEN, default 16, elements per input vector (range 2..2^ADDR_W).
REQ-002 Parameter ADDR_W, default 4, element address width.
REQ-003 Parameter DRAIN_MAX, default 8, maximum cycles spent waiting for results before flagging an error.
REQ-004 Port clock  in  1  single clock, all state updates on rising edge.
REQ-005 Port clear_n  in  1  reset; synchronous, active-low.
REQ-006 Port start  in  1  job request; sampled only in IDLE.
REQ-007 Port quadrant_cfg  in  2  quadrant for the job.
REQ-008 Port busy  out  1  high in every state except IDLE.
REQ-009 Port done  out  1  one-cycle pulse on job completion.
REQ-010 Port err  out  1  sticky drain timeout flag.
REQ-011 Port dp_clear  out  1  datapath clear (active-high).
REQ-012 Port dp_go  out  1  datapath go pulse.
REQ-013 Port elem_addr  out  ADDR_W  element read address to A/B element memories (1-cycle read latency).
REQ-014 Port elem_ready  out  1  drives datapath a/b element-ready; marks valid element data this cycle.
REQ-015 Port last_element  out  1  final element of current vector, coincident with elem_ready.
REQ-016 Port quadrant  out  2  latched quadrant_cfg for the datapath.
REQ-017 Port layer  out  2  layer currently being issued.
REQ-018 Port z_element_ready  in  1  result strobe from datapath.
REQ-019 Port z_count  out  3  results received this job (0..4).

Function
REQ-020 FSM states: IDLE, CLR, GO, ISSUE, DRAIN; one-hot or binary encoding is left to implementation.
REQ-021 IDLE: start=1 -> CLR; latch quadrant_cfg into quadrant, clear err, z_count, layer and elem_addr; start=0 -> stay.
REQ-022 CLR: dp_clear=1 for exactly one cycle; -> GO.
REQ-023 GO: dp_go=1 for exactly one cycle; elem_addr=0; -> ISSUE.
REQ-024 ISSUE: elem_addr increments by 1 each cycle, 0..VEC_LEN-1, then wraps to 0 and layer increments; after layer 3 address VEC_LEN-1 -> DRAIN.
REQ-025 elem_ready is asserted exactly one cycle after each address issued (registered); total 4*VEC_LEN consecutive elem_ready cycles per job, no bubbles.
REQ-026 last_element is asserted with the elem_ready that corresponds to address VEC_LEN-1, once per layer (4 per job).
REQ-027 The layer output tracks issue, not data; layer wraps 3->0 at DRAIN entry.
REQ-028 z_count increments on every z_element_ready while busy, saturating at 4; strobes in IDLE are ignored.
REQ-029 DRAIN: z_count reaches 4 (counting a strobe arriving this cycle) -> done=1 for one cycle, -> IDLE.
REQ-030 DRAIN: DRAIN_MAX cycles elapse without reaching 4 -> err=1, done=1 for one cycle, -> IDLE.
REQ-031 start while busy is ignored; no queuing.
REQ-032 start asserted in the cycle done pulses (state DRAIN) is ignored; start in the following IDLE cycle is accepted.
REQ-033 quadrant is held constant from CLR until the next accepted start.

Reset
REQ-034 clear_n=0 at a rising edge forces IDLE and zeros busy, done, err, dp_clear, dp_go, elem_addr, elem_ready, last_element, quadrant, layer, z_count and the drain timer.
REQ-035 Reset mid-job aborts with no done pulse; it takes priority over every other input.
REQ-036 No output depends combinationally on clear_n.

Structure
REQ-037 A shared package holds the FSM state typedef, NUM_LAYERS=4 and the result count width.
REQ-038 One sub-module, element_address_counter (ADDR_W counter with wrap and carry-out to the layer count), is instantiated; the rest is flat.

Verification (VEC_LEN=4, DRAIN_MAX=8)
REQ-039 Reset then start=1 for one cycle with quadrant_cfg=2 -> dp_clear at T+1, dp_go at T+2, elem_addr 0,1,2,3 x4 from T+2, elem_ready from T+3 for 16 cycles, quadrant=2.
REQ-040 Same job -> last_element high on elem_ready cycles 4, 8, 12, 16 only; layer 0,1,2,3.
REQ-041 Model datapath returning z_element_ready 2 cycles after each last_element -> z_count 1..4, done single pulse the cycle the 4th strobe arrives, err=0, busy drops the next cycle.
REQ-042 Return only 3 strobes -> err=1 and done pulse exactly 8 cycles after DRAIN entry; the next start clears err.
REQ-043 start held high continuously across two jobs -> second job begins one IDLE cycle after done; mid-job start pulses have no effect.
REQ-044 clear_n=0 during layer 2 issue -> next cycle all outputs zero, state IDLE, no done; a new start then runs a full correct job.

Source files
------------

// File: rtl/first_stage_sequencer_pkg.sv
// Shared types and constants for the first-stage sequencer: FSM state encoding,
// layer count and result-count width, plus the saturating result-count helper.
package first_stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_GO    = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_t;

  localparam int NUM_LAYERS = 4;
  localparam int LAYER_W    = 2;
  localparam int ZCNT_W     = 3;

  localparam logic [ZCNT_W-1:0]  ZCNT_FULL  = ZCNT_W'(NUM_LAYERS);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

  // Result count saturates once every layer has reported back.
  function automatic logic [ZCNT_W-1:0] zcount_inc(input logic [ZCNT_W-1:0] cnt);
    if (cnt >= ZCNT_FULL) begin
      zcount_inc = ZCNT_FULL;
    end else begin
      zcount_inc = cnt + ZCNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/first_stage_sequencer_counter.sv
// Element address counter: walks 0..VEC_LEN-1 while enabled, wrapping to 0 and
// raising a combinational carry on the final address so the top can step the layer.
module element_address_counter #(
  parameter int VEC_LEN = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              carry
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);

  logic [ADDR_W-1:0] addr_r;
  logic              carry_s;

  // Carry fires on the last address of a vector while issuing.
  always_comb begin
    carry_s = en && (addr_r == LAST_ADDR);
  end

  // Address register with explicit wrap so VEC_LEN need not be a power of two.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      addr_r <= '0;
    end else if (clr || carry_s) begin
      addr_r <= '0;
    end else if (en) begin
      addr_r <= addr_r + ADDR_W'(1);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr  = addr_r;
  assign carry = carry_s;

endmodule

// File: rtl/first_stage_sequencer.sv
// First-stage sequencer: clears and starts the datapath, issues four layers of
// element addresses, then waits (bounded) for four result strobes before completing.
module first_stage_sequencer
  import first_stage_sequencer_pkg::*;
#(
  parameter int VEC_LEN   = 16,
  parameter int ADDR_W    = 4,
  parameter int DRAIN_MAX = 8
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              start,
  input  logic [1:0]        quadrant_cfg,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              dp_clear,
  output logic              dp_go,
  output logic [ADDR_W-1:0] elem_addr,
  output logic              elem_ready,
  output logic              last_element,
  output logic [1:0]        quadrant,
  output logic [1:0]        layer,
  input  logic              z_element_ready,
  output logic [2:0]        z_count
);

  localparam int                TMR_W     = $clog2(DRAIN_MAX + 1);
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(DRAIN_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);

  seq_state_t         state_r;
  seq_state_t         state_next_s;
  logic               accept_s;
  logic               issue_s;
  logic               carry_s;
  logic               final_elem_s;
  logic               reach_full_s;
  logic               busy_s;
  logic               done_s;
  logic               timeout_s;
  logic               dp_clear_s;
  logic               dp_go_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [LAYER_W-1:0] layer_r;
  logic [ZCNT_W-1:0]  z_count_r;
  logic [TMR_W-1:0]   drain_tmr_r;
  logic [1:0]         quadrant_r;
  logic               elem_ready_r;
  logic               last_element_r;
  logic               err_r;

  element_address_counter #(
    .VEC_LEN (VEC_LEN),
    .ADDR_W  (ADDR_W)
  ) u_addr_cnt (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (accept_s),
    .en      (issue_s),
    .addr    (addr_s),
    .carry   (carry_s)
  );

  // Job-level decodes shared by the FSM and the datapath registers.
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && start;
    issue_s      = (state_r == ST_GO) || (state_r == ST_ISSUE);
    final_elem_s = (state_r == ST_ISSUE) && carry_s && (layer_r == LAYER_LAST);
    // A strobe arriving this cycle counts toward completion.
    reach_full_s = ((z_element_ready ? zcount_inc(z_count_r) : z_count_r) == ZCNT_FULL);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = start ? ST_CLR : ST_IDLE;
      ST_CLR:   state_next_s = ST_GO;
      ST_GO:    state_next_s = ST_ISSUE;
      ST_ISSUE: state_next_s = final_elem_s ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: state_next_s = done_s ? ST_IDLE : ST_DRAIN;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs; done is qualified by the live result strobe so it lands in DRAIN.
  always_comb begin
    busy_s     = 1'b0;
    dp_clear_s = 1'b0;
    dp_go_s    = 1'b0;
    done_s     = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE:  busy_s = 1'b0;
      ST_CLR: begin
        busy_s     = 1'b1;
        dp_clear_s = 1'b1;
      end
      ST_GO: begin
        busy_s  = 1'b1;
        dp_go_s = 1'b1;
      end
      ST_ISSUE: busy_s = 1'b1;
      ST_DRAIN: begin
        busy_s    = 1'b1;
        timeout_s = !reach_full_s && (drain_tmr_r == TMR_MAX);
        done_s    = reach_full_s || timeout_s;
      end
      default:  busy_s = 1'b0;
    endcase
  end

  // Element strobes trail the issued address by one cycle to match memory read latency.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      elem_ready_r   <= 1'b0;
      last_element_r <= 1'b0;
    end else begin
      elem_ready_r   <= issue_s;
      last_element_r <= issue_s && (addr_s == LAST_ADDR);
    end
  end

  // Per-job context: quadrant, layer, result count and the sticky error.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      quadrant_r <= 2'd0;
      layer_r    <= '0;
      z_count_r  <= '0;
      err_r      <= 1'b0;
    end else if (accept_s) begin
      quadrant_r <= quadrant_cfg;
      layer_r    <= '0;
      z_count_r  <= '0;
      err_r      <= 1'b0;
    end else begin
      quadrant_r <= quadrant_r;
      layer_r    <= carry_s ? (layer_r + LAYER_W'(1)) : layer_r;
      z_count_r  <= (busy_s && z_element_ready) ? zcount_inc(z_count_r) : z_count_r;
      err_r      <= err_r || timeout_s;
    end
  end

  // Drain timer counts cycles spent in DRAIN and rests at zero otherwise.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      drain_tmr_r <= '0;
    end else if (state_r == ST_DRAIN) begin
      drain_tmr_r <= drain_tmr_r + TMR_W'(1);
    end else begin
      drain_tmr_r <= '0;
    end
  end

  assign busy         = busy_s;
  assign done         = done_s;
  assign err          = err_r || timeout_s;
  assign dp_clear     = dp_clear_s;
  assign dp_go        = dp_go_s;
  assign elem_addr    = addr_s;
  assign elem_ready   = elem_ready_r;
  assign last_element = last_element_r;
  assign quadrant     = quadrant_r;
  assign layer        = layer_r;
  assign z_count      = z_count_r;

endmodule
